// File: rtl/uart_rx_core.sv
// UART receiver: oversampled start detect, 2-of-3 majority bit sampling, LSB-first data, optional parity, stop check.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer before the FSM.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  par_err,
  output logic                  stp_err
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO      = PRESCALE_W'(2);
  localparam logic [CW-1:0]         BIT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [PRESCALE_W-1:0] legal_presc(input logic [PRESCALE_W-1:0] p);
    if (p == PRESCALE_W'(8) || p == PRESCALE_W'(16) || p == PRESCALE_W'(32))
      legal_presc = p;
    else
      legal_presc = PRESCALE_W'(8);
  endfunction

  function automatic logic majority(input logic [2:0] s);
    majority = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  logic rx_s;
`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], RX_IN};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_q, edge_d, presc_q, presc_d;
  logic [CW-1:0]           bit_q, bit_d;
  logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic [2:0]              samp_q, samp_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d, p_data_q, p_data_d;
  logic                    par_fail_q, par_fail_d;
  logic                    dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;

  logic [PRESCALE_W-1:0]   half;
  logic                    bit_end, in_window, maj;

  assign half      = presc_q >> 1;
  assign bit_end   = (edge_q == presc_q - ONE);
  assign in_window = (edge_q == half - ONE) || (edge_q == half) || (edge_q == half + ONE);
  assign maj       = majority(samp_q);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_fail_d = par_fail_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + ONE;
      if (in_window) samp_d = {samp_q[1:0], rx_s};
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        if (!rx_s) begin
          state_d    = START;
          presc_d    = legal_presc(Prescale);
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          bit_d      = '0;
        end
      end
      START: begin
        // A high majority right after the sample window means the low level was a glitch.
        if (edge_q == half + TWO && maj) begin
          state_d = IDLE;
          edge_d  = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_fail_d = (maj != ((^shift_q) ^ par_typ_q));
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          if (!maj || par_fail_q) begin
            perr_d = par_fail_q;
            serr_d = !maj;
          end else begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= PRESCALE_W'(8);
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_fail_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_fail_q <= par_fail_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: table of frames plus hand-written corner sequences,
// with a scoreboard of expected outputs and pulse timing checked when each pulse appears.
module tb_uart_rx_core;
  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] Prescale = 6'd8;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, par_err, stp_err;

  uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // exp packs {Data_Valid, par_err, stp_err, P_DATA}
  typedef struct {
    logic [PW-1:0] presc;
    int            bitp;
    logic          pen;
    logic          ptyp;
    logic [7:0]    data;
    logic          pbit;
    logic          sbit;
    logic [10:0]   exp;
  } vec_t;

  typedef struct {
    logic [10:0] outs;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[11];
  int   n_vec = 0;
  int   n_miss = 0;
  int   pulse_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge; drives one full frame on RX_IN and queues the expected result.
  task automatic send_frame(input logic [PW-1:0] presc, input int bitp, input logic pen,
                            input logic ptyp, input logic [7:0] data, input logic pbit,
                            input logic sbit, input logic [10:0] exp_outs, input int extra,
                            input bit use_mid, input logic [PW-1:0] mid_p);
    int nbits;
    exp_t e;
    Prescale = presc;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    nbits    = 10 + int'(pen);
    e.outs   = exp_outs;
    e.cyc    = cyc + 1 + nbits * bitp + extra + SYNC_LAT;
    sbq.push_back(e);
    RX_IN = 1'b0;
    repeat (bitp) @(negedge clk);
    if (use_mid) Prescale = mid_p;
    for (int i = 0; i < 8; i++) begin
      RX_IN = data[i];
      repeat (bitp) @(negedge clk);
    end
    if (pen) begin
      RX_IN = pbit;
      repeat (bitp) @(negedge clk);
    end
    RX_IN = sbit;
    repeat (bitp) @(negedge clk);
  endtask

  task automatic monitor();
    bit   prev;
    logic pulse;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        continue;
      end
      pulse = Data_Valid | par_err | stp_err;
      if (prev) check("pulse_width", {31'd0, pulse}, 32'd0);
      if (pulse) begin
        pulse_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_pulse", {21'd0, Data_Valid, par_err, stp_err, P_DATA}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("frame_outputs", {21'd0, Data_Valid, par_err, stp_err, P_DATA}, {21'd0, e.outs});
          check("frame_latency", cyc, e.cyc);
        end
      end
      prev = pulse;
    end
  endtask

  initial begin
    int         base;
    logic [7:0] rd;
    //           presc bitp pen ptyp data   pbit sbit  {dv,perr,serr,pdata}
    vecs[0]  = '{6'd8,  8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, {3'b100, 8'h5A}};
    vecs[1]  = '{6'd8,  8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, {3'b010, 8'h5A}};
    vecs[2]  = '{6'd8,  8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, {3'b100, 8'hA5}};
    vecs[3]  = '{6'd8,  8,  1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, {3'b100, 8'hA5}};
    vecs[4]  = '{6'd16, 16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, {3'b001, 8'hA5}};
    vecs[5]  = '{6'd16, 16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, {3'b100, 8'h3C}};
    vecs[6]  = '{6'd8,  8,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, {3'b011, 8'h3C}};
    vecs[7]  = '{6'd32, 32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, {3'b100, 8'h01}};
    vecs[8]  = '{6'd12, 8,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, {3'b100, 8'hC3}};
    vecs[9]  = '{6'd8,  8,  1'b1, 1'b0, 8'h07, 1'b1, 1'b1, {3'b100, 8'h07}};
    vecs[10] = '{6'd16, 16, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, {3'b010, 8'h07}};

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("reset_outputs", {21'd0, Data_Valid, par_err, stp_err, P_DATA}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_outputs", {21'd0, Data_Valid, par_err, stp_err, P_DATA}, 32'd0);

    foreach (vecs[i]) begin
      send_frame(vecs[i].presc, vecs[i].bitp, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                 vecs[i].pbit, vecs[i].sbit, vecs[i].exp, 0, 1'b0, 6'd0);
      RX_IN = 1'b1;
      repeat (6) @(negedge clk);
    end

    // Short low glitch on an idle line must not produce any pulse.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    base     = pulse_cnt;
    RX_IN    = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (120) @(negedge clk);
    check("glitch_no_pulse", pulse_cnt, base);
    send_frame(6'd8, 8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, {3'b100, 8'h96}, 0, 1'b0, 6'd0);
    RX_IN = 1'b1;
    repeat (6) @(negedge clk);

    // Back-to-back frames: the second start edge is seen one cycle late.
    send_frame(6'd32, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, {3'b100, 8'h00}, 0, 1'b0, 6'd0);
    send_frame(6'd32, 32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, {3'b100, 8'hFF}, 1, 1'b0, 6'd0);
    RX_IN = 1'b1;
    repeat (6) @(negedge clk);
    send_frame(6'd32, 32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, {3'b100, 8'h00}, 0, 1'b1, 6'd8);
    send_frame(6'd32, 32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, {3'b100, 8'hFF}, 1, 1'b0, 6'd0);
    RX_IN = 1'b1;
    repeat (6) @(negedge clk);

    // Reset during data bit 4 aborts the frame and clears outputs.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    rd       = 8'h81;
    RX_IN    = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX_IN = rd[i];
      repeat (8) @(negedge clk);
    end
    RX_IN = rd[4];
    repeat (3) @(negedge clk);
    base  = pulse_cnt;
    rst   = 1'b1;
    RX_IN = 1'b1;
    @(negedge clk);
    check("reset_abort_outputs", {21'd0, Data_Valid, par_err, stp_err, P_DATA}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("reset_abort_no_pulse", pulse_cnt, base);
    send_frame(6'd8, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, {3'b100, 8'h81}, 0, 1'b0, 6'd0);
    RX_IN = 1'b1;

    for (int k = 0; k < 500 && sbq.size() > 0; k++) @(negedge clk);
    check("scoreboard_drain", sbq.size(), 32'd0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
